// File: rtl/display_capture.sv
// ---------------------------------------------------------------------------
// display_capture
//
// Sink-side panel model for the display DataPath. Watches the blanking and
// active-pixel strobes, rebuilds the pixel X/Y position and writes every
// active pixel into a frame buffer write port. Line and frame geometry are
// checked against H_ACTIVE / V_ACTIVE. Clean frames are reported and counted,
// and bad geometry is flagged.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   CSDisplay            chip select; when low, everything holds
//   HBOut_PD, VBOut_PD   horizontal / vertical blank from DataPath
//   AIPOut_PD, AILOut_PD active-pixel / active-line qualifiers
//   pix_in               pixel word, valid when AIPOut_PD & AILOut_PD
//   wr_en/addr/data      frame buffer write port (registered, 1-cycle latency)
//   x_cnt, y_cnt         current column / line
//   frame_done           1-cycle pulse, clean frame completed
//   frame_count          number of clean frames (wraps)
//   line_err             1-cycle pulse, line length != H_ACTIVE
//   frame_err            1-cycle pulse, bad line count or pixel overflow
//   synced               high once the first frame start has been seen
// ---------------------------------------------------------------------------
module display_capture #(
  parameter int PIXEL_W  = 32,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int CNT_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CSDisplay,
  input  logic               HBOut_PD,
  input  logic               VBOut_PD,
  input  logic               AIPOut_PD,
  input  logic               AILOut_PD,
  input  logic [PIXEL_W-1:0] pix_in,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data,
  output logic [CNT_W-1:0]   x_cnt,
  output logic [CNT_W-1:0]   y_cnt,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               line_err,
  output logic               frame_err,
  output logic               synced
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HBLANK = 2'd3;

  localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_ACTIVE);

  logic [1:0]         state_reg, state_next;
  logic               hb_prev_reg, hb_prev_next;
  logic               vb_prev_reg, vb_prev_next;
  logic [CNT_W-1:0]   x_reg, x_next;
  logic [CNT_W-1:0]   y_reg, y_next;
  logic               dirty_reg, dirty_next;
  logic               ovf_line_reg, ovf_line_next;
  logic               wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
  logic [PIXEL_W-1:0] wr_data_reg, wr_data_next;
  logic               frame_done_reg, frame_done_next;
  logic [15:0]        frame_count_reg, frame_count_next;
  logic               line_err_reg, line_err_next;
  logic               frame_err_reg, frame_err_next;
  logic               synced_reg, synced_next;

  logic hb_rise, vb_rise, pix_valid, blank;
  logic take, close_line, end_frame;

  assign hb_rise   = HBOut_PD & ~hb_prev_reg;
  assign vb_rise   = VBOut_PD & ~vb_prev_reg;
  assign pix_valid = AIPOut_PD & AILOut_PD;
  assign blank     = HBOut_PD | VBOut_PD;

  always_comb begin
    state_next       = state_reg;
    hb_prev_next     = hb_prev_reg;
    vb_prev_next     = vb_prev_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    dirty_next       = dirty_reg;
    ovf_line_next    = ovf_line_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    frame_done_next  = 1'b0;
    frame_count_next = frame_count_reg;
    line_err_next    = 1'b0;
    frame_err_next   = 1'b0;
    synced_next      = synced_reg;
    take             = 1'b0;
    close_line       = 1'b0;
    end_frame        = 1'b0;

    if (CSDisplay) begin
      hb_prev_next = HBOut_PD;
      vb_prev_next = VBOut_PD;

      case (state_reg)
        ST_SYNC: begin
          if (vb_rise) begin
            state_next  = ST_VBLANK;
            synced_next = 1'b1;
          end
        end
        ST_VBLANK: begin
          if (pix_valid && !blank) begin
            take       = 1'b1;
            state_next = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A pixel arriving together with the closing blank edge is still
          // taken; the line is then closed on the updated column count.
          take       = pix_valid;
          close_line = hb_rise | vb_rise;
          end_frame  = vb_rise;
          if (hb_rise) state_next = ST_HBLANK;
        end
        default: begin // ST_HBLANK
          if (vb_rise) begin
            end_frame = 1'b1;
          end else if (pix_valid && !blank) begin
            take       = 1'b1;
            state_next = ST_ACTIVE;
          end
        end
      endcase

      if (take) begin
        if (x_next == H_LIM || y_next == V_LIM) begin
          // Outside the frame: drop it; x saturates at H_ACTIVE so the line
          // check does not double-report an over-long line.
          dirty_next = 1'b1;
          if (!ovf_line_next) frame_err_next = 1'b1;
          ovf_line_next = 1'b1;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = ADDR_W'(y_next) * H_STRIDE + ADDR_W'(x_next);
          wr_data_next = pix_in;
          x_next       = x_next + CNT_W'(1);
        end
      end

      if (close_line) begin
        if (x_next != H_LIM) begin
          line_err_next = 1'b1;
          dirty_next    = 1'b1;
        end
        x_next        = '0;
        ovf_line_next = 1'b0;
        // Saturate so surplus lines cannot wrap the address; they are
        // already caught as dirty by the line check or the overflow path.
        if (y_next != V_LIM) y_next = y_next + CNT_W'(1);
      end

      if (end_frame) begin
        if (y_next == V_LIM && !dirty_next) begin
          frame_done_next  = 1'b1;
          frame_count_next = frame_count_reg + 16'd1;
        end else begin
          frame_err_next = 1'b1;
        end
        dirty_next    = 1'b0;
        ovf_line_next = 1'b0;
        x_next        = '0;
        y_next        = '0;
        state_next    = ST_VBLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_SYNC;
      hb_prev_reg     <= 1'b0;
      vb_prev_reg     <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      dirty_reg       <= 1'b0;
      ovf_line_reg    <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
      line_err_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      synced_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hb_prev_reg     <= hb_prev_next;
      vb_prev_reg     <= vb_prev_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      dirty_reg       <= dirty_next;
      ovf_line_reg    <= ovf_line_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
      line_err_reg    <= line_err_next;
      frame_err_reg   <= frame_err_next;
      synced_reg      <= synced_next;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign x_cnt       = x_reg;
  assign y_cnt       = y_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign line_err    = line_err_reg;
  assign frame_err   = frame_err_reg;
  assign synced      = synced_reg;

endmodule

// File: tb/tb_display_capture.sv
// ---------------------------------------------------------------------------
// tb_display_capture
//
// Directed bench for display_capture with a 4x2 frame. Inputs are driven 1 ns
// after the rising edge and outputs are sampled 1 ns after the next edge, so
// each tick shows the registered response to the inputs of that cycle.
// ---------------------------------------------------------------------------
module tb_display_capture;

  localparam int PW = 32;
  localparam int HA = 4;
  localparam int VA = 2;
  localparam int AW = 19;
  localparam int CW = 10;

  logic          clk;
  logic          reset;
  logic          cs, hb, vb, aip, ail;
  logic [PW-1:0] pix;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic [CW-1:0] x_cnt, y_cnt;
  logic          frame_done, line_err, frame_err, synced;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_lerr = 0;
  int n_ferr = 0;
  int wa[$];
  int wd[$];

  display_capture #(
    .PIXEL_W(PW), .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .CSDisplay(cs),
    .HBOut_PD(hb), .VBOut_PD(vb), .AIPOut_PD(aip), .AILOut_PD(ail),
    .pix_in(pix),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_cnt(x_cnt), .y_cnt(y_cnt),
    .frame_done(frame_done), .frame_count(frame_count),
    .line_err(line_err), .frame_err(frame_err), .synced(synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, step past the edge, log what came out.
  task automatic tick(input logic c, input logic h, input logic v,
                      input logic act, input logic [31:0] p);
    cs = c; hb = h; vb = v; aip = act; ail = act; pix = p;
    @(posedge clk);
    #1;
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      $display("WR   addr=%0d data=%08h x=%0d y=%0d", wr_addr, wr_data, x_cnt, y_cnt);
    end
    if (frame_done) begin n_done++; $display("DONE frame_count=%0d", frame_count); end
    if (line_err)   begin n_lerr++; $display("LERR y=%0d", y_cnt); end
    if (frame_err)  begin n_ferr++; $display("FERR"); end
  endtask

  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 1, 32'(base + i));
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
  endtask

  task automatic send_vblank();
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete();
    n_done = 0; n_lerr = 0; n_ferr = 0;
  endtask

  initial begin
    reset = 1'b1;
    cs = 0; hb = 0; vb = 0; aip = 0; ail = 0; pix = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_x", 32'(x_cnt), 0);
    chk("rst_y", 32'(y_cnt), 0);
    chk("rst_fcount", 32'(frame_count), 0);
    chk("rst_synced", 32'(synced), 0);
    reset = 1'b0;

    // Two clean frames, preceded by a partial frame that must be ignored.
    clear_log();
    send_line(2, 32'hAA);
    chk("pre_sync_writes", 32'(wa.size()), 0);
    chk("pre_sync_synced", 32'(synced), 0);
    send_vblank();
    chk("synced", 32'(synced), 1);
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 0, 1, 2);
    chk("mid_x", 32'(x_cnt), 2);
    tick(1, 0, 0, 1, 3);
    tick(1, 0, 0, 1, 4);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("after_line_y", 32'(y_cnt), 1);
    send_line(4, 5);
    send_vblank();
    send_line(4, 9);
    send_line(4, 13);
    send_vblank();
    chk("f12_writes", 32'(wa.size()), 16);
    for (int i = 0; i < wa.size(); i++) begin
      chk("f12_addr", 32'(wa[i]), 32'(i % 8));
      chk("f12_data", 32'(wd[i]), 32'(i + 1));
    end
    chk("f12_done", 32'(n_done), 2);
    chk("f12_fcount", 32'(frame_count), 2);
    chk("f12_lerr", 32'(n_lerr), 0);
    chk("f12_ferr", 32'(n_ferr), 0);

    // Short line: 3 pixels.
    clear_log();
    send_line(3, 32'h30);
    chk("short_lerr", 32'(n_lerr), 1);
    send_line(4, 32'h40);
    send_vblank();
    chk("short_writes", 32'(wa.size()), 7);
    chk("short_l1_addr", 32'(wa[3]), 4);
    chk("short_ferr", 32'(n_ferr), 1);
    chk("short_done", 32'(n_done), 0);
    chk("short_fcount", 32'(frame_count), 2);

    // Long line: 5th pixel dropped.
    clear_log();
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 32'(32'h50 + i));
    tick(1, 0, 0, 1, 32'h54);
    chk("long_5th_wr_en", 32'(wr_en), 0);
    chk("long_5th_ferr", 32'(frame_err), 1);
    chk("long_x_sat", 32'(x_cnt), 4);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    send_line(4, 32'h60);
    send_vblank();
    chk("long_writes", 32'(wa.size()), 8);
    chk("long_last_l0_addr", 32'(wa[3]), 3);
    chk("long_last_l0_data", 32'(wd[3]), 32'h53);
    chk("long_lerr", 32'(n_lerr), 0);
    chk("long_ferr", 32'(n_ferr), 2);
    chk("long_done", 32'(n_done), 0);
    chk("long_fcount", 32'(frame_count), 2);

    // Chip select dropped mid-line.
    clear_log();
    tick(1, 0, 0, 1, 32'h70);
    tick(1, 0, 0, 1, 32'h71);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 32'hDEAD);
      chk("cs0_wr_en", 32'(wr_en), 0);
      chk("cs0_x", 32'(x_cnt), 2);
    end
    tick(1, 0, 0, 1, 32'h72);
    chk("cs_resume_addr", 32'(wr_addr), 2);
    chk("cs_resume_data", 32'(wr_data), 32'h72);
    tick(1, 0, 0, 1, 32'h73);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    send_line(4, 32'h74);
    send_vblank();
    chk("cs_writes", 32'(wa.size()), 8);
    chk("cs_done", 32'(n_done), 1);
    chk("cs_fcount", 32'(frame_count), 3);

    // Reset after 5 pixels of a frame.
    clear_log();
    send_line(4, 32'h80);
    tick(1, 0, 0, 1, 32'h84);
    reset = 1'b1;
    tick(1, 0, 0, 0, 0);
    reset = 1'b0;
    chk("mrst_wr_en", 32'(wr_en), 0);
    chk("mrst_addr", 32'(wr_addr), 0);
    chk("mrst_x", 32'(x_cnt), 0);
    chk("mrst_y", 32'(y_cnt), 0);
    chk("mrst_fcount", 32'(frame_count), 0);
    chk("mrst_synced", 32'(synced), 0);
    clear_log();
    send_line(4, 32'h90);
    chk("mrst_nowrite", 32'(wa.size()), 0);
    chk("mrst_synced2", 32'(synced), 0);
    send_vblank();
    chk("mrst_resync", 32'(synced), 1);
    send_line(4, 32'hA0);
    send_line(4, 32'hA4);
    send_vblank();
    chk("mrst_first_addr", 32'(wa[0]), 0);
    chk("mrst_first_data", 32'(wd[0]), 32'hA0);
    chk("mrst_fcount2", 32'(frame_count), 1);

    // HB and VB rise together at the end of the last line.
    clear_log();
    send_line(4, 32'hB0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 32'(32'hB4 + i));
    chk("hv_pre_x", 32'(x_cnt), 4);
    chk("hv_pre_y", 32'(y_cnt), 1);
    tick(1, 1, 1, 0, 0);
    chk("hv_done", 32'(frame_done), 1);
    tick(1, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("hv_done_count", 32'(n_done), 1);
    chk("hv_ferr", 32'(n_ferr), 0);
    chk("hv_fcount", 32'(frame_count), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
